// File: rtl/csr_file_pkg.sv
// csr_file_pkg: shared definitions for the machine-mode CSR file.
// Holds CSR addresses, csr_op encodings, the CSR request payload,
// WARL masks, mstatus bit positions and the RMW helper.
package csr_file_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Request payload driven by ex.
  typedef struct packed {
    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
  } csr_req_t;

  // CSR address map
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINH = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  // WARL masks
  localparam logic [31:0] MIE_MASK       = 32'h0000_0888;
  localparam logic [31:0] MCOUNTINH_MASK = 32'h0000_0005;
  localparam logic [31:0] MEPC_MASK      = 32'hFFFF_FFFC;
  localparam logic [31:0] MTVEC_MASK_DIR = 32'hFFFF_FFFC;
  localparam logic [31:0] MTVEC_MASK_VEC = 32'hFFFF_FFFD;
  localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;

  // Bit positions
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned IRQ_SW_BIT       = 3;
  localparam int unsigned IRQ_TIMER_BIT    = 7;
  localparam int unsigned IRQ_EXT_BIT      = 11;
  localparam int unsigned CNT_CY_BIT       = 0;
  localparam int unsigned CNT_IR_BIT       = 2;

  // Read-modify-write result for one CSR operation.
  function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wdata;
      CSR_OP_RS: res = old_val | wdata;
      CSR_OP_RC: res = old_val & ~wdata;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: CSR instruction bus between ex (master) and csr_file (slave).
//   req     : op / addr / wdata from ex
//   rdata   : pre-write CSR value (combinational)
//   illegal : access is illegal, no state change
interface csr_file_if;
  import csr_file_pkg::*;

  csr_req_t    req;
  logic [31:0] rdata;
  logic        illegal;

  modport master (output req, input rdata, input illegal);
  modport slave  (input req, output rdata, output illegal);
endinterface

// File: rtl/csr_counter.sv
// csr_counter: CNT_W-bit free-running counter with increment enable,
// inhibit and 32-bit lo/hi write ports. A write replaces its half and
// suppresses that cycle's increment.
//   clk, rst_n         : clock, async active-low reset
//   inc_i, inhibit_i   : count request, count inhibit
//   wr_lo_i, wr_hi_i   : write bits [31:0] / [CNT_W-1:32] from wdata_i
//   cnt_o              : current count
module csr_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             inhibit_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: writes win over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i) begin
      cnt_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      cnt_d[CNT_W-1:32] = wdata_i[HI_W-1:0];
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file. Executes CSRRW/RS/RC with WARL masking,
// flags illegal accesses, runs mcycle/minstret, applies trap entry and
// mret updates, and produces the trap vector and pending-interrupt flag.
//   clk, rst_n                  : clock, async active-low reset
//   csr_bus (slave)             : CSR request / rdata / illegal
//   instret_i                   : one instruction retired
//   trap_i, trap_cause_i, trap_pc_i : trap-entry strobe and payload
//   mret_i                      : mret strobe
//   irq_sw_i/irq_timer_i/irq_ext_i : level interrupt sources
//   trap_vector_o               : handler address (combinational)
//   mepc_o, global_int_en_o     : mepc, mstatus.MIE
//   irq_pending_o               : enabled interrupt pending (combinational)
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned CNT_W       = 64,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] RESET_MTVEC = 32'h0,
  parameter bit          VECTORED_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  csr_file_if.slave   csr_bus,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        global_int_en_o,
  output logic        irq_pending_o
);

  localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? MTVEC_MASK_VEC : MTVEC_MASK_DIR;

  // Architectural state
  logic        mstatus_mie_q,  mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q,          mie_d;
  logic [31:0] mtvec_q,        mtvec_d;
  logic [31:0] mcountinh_q,    mcountinh_d;
  logic [31:0] mscratch_q,     mscratch_d;
  logic [31:0] mepc_q,         mepc_d;
  logic [31:0] mcause_q,       mcause_d;
  logic [31:0] mip_q,          mip_d;

  logic [CNT_W-1:0] mcycle_cnt, minstret_cnt;
  logic [63:0]      mcycle_ext, minstret_ext;

  // Request decode
  csr_op_e     op;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd_val;
  logic [31:0] mstatus_rd;
  logic [31:0] wr_val;
  logic        mapped;
  logic        wants_write;
  logic        illegal;
  logic        wr_en;

  assign op    = csr_bus.req.op;
  assign addr  = csr_bus.req.addr;
  assign wdata = csr_bus.req.wdata;

  assign mcycle_ext   = 64'(mcycle_cnt);
  assign minstret_ext = 64'(minstret_cnt);

  // mstatus view: MPP is hardwired to M-mode.
  always_comb begin
    mstatus_rd                   = MSTATUS_MPP_RO;
    mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
    mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
  end

  // Read mux; unmapped addresses read 0.
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (addr)
      ADDR_MSTATUS:   rd_val = mstatus_rd;
      ADDR_MISA:      rd_val = MISA_VAL;
      ADDR_MIE:       rd_val = mie_q;
      ADDR_MTVEC:     rd_val = mtvec_q;
      ADDR_MCOUNTINH: rd_val = mcountinh_q;
      ADDR_MSCRATCH:  rd_val = mscratch_q;
      ADDR_MEPC:      rd_val = mepc_q;
      ADDR_MCAUSE:    rd_val = mcause_q;
      ADDR_MIP:       rd_val = mip_q;
      ADDR_MCYCLE,
      ADDR_CYCLE:     rd_val = mcycle_ext[31:0];
      ADDR_MCYCLEH,
      ADDR_CYCLEH:    rd_val = mcycle_ext[63:32];
      ADDR_MINSTRET,
      ADDR_INSTRET:   rd_val = minstret_ext[31:0];
      ADDR_MINSTRETH,
      ADDR_INSTRETH:  rd_val = minstret_ext[63:32];
      ADDR_MHARTID:   rd_val = HART_ID;
      default:        mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never writes.
  assign wants_write = (op == CSR_OP_RW) ||
                       (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (wdata != 32'h0));
  assign illegal     = (op != CSR_OP_NONE) &&
                       (!mapped || (wants_write && (addr[11:10] == 2'b11)));
  assign wr_en       = wants_write && !illegal;
  assign wr_val      = csr_apply_op(op, rd_val, wdata);

  assign csr_bus.rdata   = rd_val;
  assign csr_bus.illegal = illegal;

  // Next state: CSR writes first, then mret, then trap, so the
  // higher-priority event overrides any register it touches.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mcountinh_d    = mcountinh_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mip_d                = '0;
    mip_d[IRQ_SW_BIT]    = irq_sw_i;
    mip_d[IRQ_TIMER_BIT] = irq_timer_i;
    mip_d[IRQ_EXT_BIT]   = irq_ext_i;

    if (wr_en) begin
      case (addr)
        ADDR_MSTATUS: begin
          mstatus_mie_d  = wr_val[MSTATUS_MIE_BIT];
          mstatus_mpie_d = wr_val[MSTATUS_MPIE_BIT];
        end
        ADDR_MIE:       mie_d       = wr_val & MIE_MASK;
        ADDR_MTVEC:     mtvec_d     = wr_val & MTVEC_MASK;
        ADDR_MCOUNTINH: mcountinh_d = wr_val & MCOUNTINH_MASK;
        ADDR_MSCRATCH:  mscratch_d  = wr_val;
        ADDR_MEPC:      mepc_d      = wr_val & MEPC_MASK;
        ADDR_MCAUSE:    mcause_d    = wr_val;
        default: ;
      endcase
    end

    if (trap_i) begin
      mepc_d         = trap_pc_i & MEPC_MASK;
      mcause_d       = trap_cause_i;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mcountinh_q    <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mip_q          <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mcountinh_q    <= mcountinh_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mip_q          <= mip_d;
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (1'b1),
    .inhibit_i (mcountinh_q[CNT_CY_BIT]),
    .wr_lo_i   (wr_en && (addr == ADDR_MCYCLE)),
    .wr_hi_i   (wr_en && (addr == ADDR_MCYCLEH)),
    .wdata_i   (wr_val),
    .cnt_o     (mcycle_cnt)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (instret_i),
    .inhibit_i (mcountinh_q[CNT_IR_BIT]),
    .wr_lo_i   (wr_en && (addr == ADDR_MINSTRET)),
    .wr_hi_i   (wr_en && (addr == ADDR_MINSTRETH)),
    .wdata_i   (wr_val),
    .cnt_o     (minstret_cnt)
  );

  // Vectored mode only offsets asynchronous causes.
  always_comb begin
    trap_vector_o = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && trap_cause_i[31]) begin
      trap_vector_o = {mtvec_q[31:2], 2'b00} + {25'h0, trap_cause_i[4:0], 2'b00};
    end
  end

  assign mepc_o          = mepc_q;
  assign global_int_en_o = mstatus_mie_q;
  assign irq_pending_o   = (|(mip_q & mie_q)) & mstatus_mie_q;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  import csr_file_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instret_i;
  logic        trap_i;
  logic [31:0] trap_cause_i;
  logic [31:0] trap_pc_i;
  logic        mret_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic [31:0] trap_vector_o;
  logic [31:0] mepc_o;
  logic        global_int_en_o;
  logic        irq_pending_o;

  int checks = 0;
  int errors = 0;

  csr_file_if bus ();

  csr_file #(
    .CNT_W       (40),
    .HART_ID     (32'd5),
    .RESET_MTVEC (32'h0000_1001),
    .VECTORED_EN (1'b0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .csr_bus         (bus),
    .instret_i       (instret_i),
    .trap_i          (trap_i),
    .trap_cause_i    (trap_cause_i),
    .trap_pc_i       (trap_pc_i),
    .mret_i          (mret_i),
    .irq_sw_i        (irq_sw_i),
    .irq_timer_i     (irq_timer_i),
    .irq_ext_i       (irq_ext_i),
    .trap_vector_o   (trap_vector_o),
    .mepc_o          (mepc_o),
    .global_int_en_o (global_int_en_o),
    .irq_pending_o   (irq_pending_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CSR op held across one rising edge; returns pre-edge rdata/illegal.
  task automatic csr_do(input csr_op_e op, input logic [11:0] addr, input logic [31:0] wd,
                        output logic [31:0] old, output logic ill);
    bus.req.op    = op;
    bus.req.addr  = addr;
    bus.req.wdata = wd;
    #1;
    old = bus.rdata;
    ill = bus.illegal;
    @(posedge clk);
    #1;
    bus.req.op    = CSR_OP_NONE;
    bus.req.wdata = '0;
  endtask

  task automatic csr_rd(input logic [11:0] addr, output logic [31:0] v);
    bus.req.op   = CSR_OP_NONE;
    bus.req.addr = addr;
    #1;
    v = bus.rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (3) tick();
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mcycle: got %h exp %h", v, 32'h0); end
    csr_rd(ADDR_MTVEC, v);
    checks++; if (v !== 32'h1001) begin errors++; $display("FAIL reset_mtvec: got %h exp %h", v, 32'h1001); end
    csr_rd(ADDR_MSTATUS, v);
    checks++; if (v !== 32'h1800) begin errors++; $display("FAIL reset_mstatus: got %h exp %h", v, 32'h1800); end
    checks++; if ({global_int_en_o, irq_pending_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {global_int_en_o, irq_pending_o}); end
    checks++; if (mepc_o !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h exp %h", mepc_o, 32'h0); end
    trap_cause_i = 32'h8000_000B;
    #1;
    checks++; if (trap_vector_o !== 32'h102C) begin errors++; $display("FAIL vec_async: got %h exp %h", trap_vector_o, 32'h102C); end
    trap_cause_i = 32'h0000_0002;
    #1;
    checks++; if (trap_vector_o !== 32'h1000) begin errors++; $display("FAIL vec_sync: got %h exp %h", trap_vector_o, 32'h1000); end
    trap_cause_i = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_warl();
    logic [31:0] v, old;
    logic ill;
    csr_do(CSR_OP_RW, ADDR_MTVEC, 32'h8000_0003, old, ill);
    csr_rd(ADDR_MTVEC, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_warl: got %h exp %h", v, 32'h8000_0000); end
    trap_cause_i = 32'h8000_000B;
    #1;
    checks++; if (trap_vector_o !== 32'h8000_0000) begin errors++; $display("FAIL vec_direct: got %h exp %h", trap_vector_o, 32'h8000_0000); end
    trap_cause_i = '0;
    csr_do(CSR_OP_RW, ADDR_MSTATUS, 32'hFFFF_FFFF, old, ill);
    csr_rd(ADDR_MSTATUS, v);
    checks++; if (v !== 32'h1888) begin errors++; $display("FAIL mstatus_warl: got %h exp %h", v, 32'h1888); end
    csr_do(CSR_OP_RC, ADDR_MSTATUS, 32'h88, old, ill);
    checks++; if (old !== 32'h1888) begin errors++; $display("FAIL rc_old: got %h exp %h", old, 32'h1888); end
    csr_rd(ADDR_MSTATUS, v);
    checks++; if (v !== 32'h1800) begin errors++; $display("FAIL rc_result: got %h exp %h", v, 32'h1800); end
    csr_do(CSR_OP_RS, ADDR_MSTATUS, 32'h8, old, ill);
    checks++; if (global_int_en_o !== 1'b1) begin errors++; $display("FAIL rs_mie: got %b exp 1", global_int_en_o); end
    csr_do(CSR_OP_RW, ADDR_MIE, 32'hFFFF_FFFF, old, ill);
    csr_rd(ADDR_MIE, v);
    checks++; if (v !== 32'h888) begin errors++; $display("FAIL mie_warl: got %h exp %h", v, 32'h888); end
    csr_do(CSR_OP_RW, ADDR_MIE, 32'h0, old, ill);
    csr_do(CSR_OP_RW, ADDR_MEPC, 32'h1234_5677, old, ill);
    checks++; if (mepc_o !== 32'h1234_5674) begin errors++; $display("FAIL mepc_warl: got %h exp %h", mepc_o, 32'h1234_5674); end
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'hFFFF_FFFF, old, ill);
    csr_rd(ADDR_MCOUNTINH, v);
    checks++; if (v !== 32'h5) begin errors++; $display("FAIL mcountinh_warl: got %h exp %h", v, 32'h5); end
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'h0, old, ill);
    csr_do(CSR_OP_RW, ADDR_MSCRATCH, 32'hDEAD_BEEF, old, ill);
    csr_rd(ADDR_MSCRATCH, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mscratch: got %h exp %h", v, 32'hDEAD_BEEF); end
  endtask

  task automatic test_counters();
    logic [31:0] v, old;
    logic ill;
    csr_do(CSR_OP_RW, ADDR_MCYCLE, 32'hFFFF_FFFF, old, ill);
    csr_do(CSR_OP_RW, ADDR_MCYCLEH, 32'h0, old, ill);
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_lo_wr: got %h exp %h", v, 32'hFFFF_FFFF); end
    tick();
    csr_rd(ADDR_MCYCLEH, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL mcycle_carry: got %h exp %h", v, 32'h1); end
    csr_rd(ADDR_CYCLEH, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL cycleh_mirror: got %h exp %h", v, 32'h1); end
    csr_do(CSR_OP_RW, ADDR_MCYCLEH, 32'hFFFF_FFFF, old, ill);
    csr_rd(ADDR_MCYCLEH, v);
    checks++; if (v !== 32'h0000_00FF) begin errors++; $display("FAIL mcycleh_width: got %h exp %h", v, 32'hFF); end
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL hi_wr_drop_inc: got %h exp %h", v, 32'h0); end
    csr_do(CSR_OP_RW, ADDR_MCYCLE, 32'hFFFF_FFFF, old, ill);
    tick();
    csr_rd(ADDR_MCYCLEH, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL mcycle_wrap: got %h exp %h", v, 32'h0); end
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'h1, old, ill);
    tick();
    tick();
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL cy_inhibit: got %h exp %h", v, 32'h1); end
    csr_do(CSR_OP_RW, ADDR_MCYCLE, 32'h1234, old, ill);
    tick();
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h1234) begin errors++; $display("FAIL inhibit_wr_persist: got %h exp %h", v, 32'h1234); end
    csr_do(CSR_OP_RW, ADDR_MINSTRET, 32'd10, old, ill);
    instret_i = 1'b1;
    repeat (3) tick();
    instret_i = 1'b0;
    csr_rd(ADDR_INSTRET, v);
    checks++; if (v !== 32'd13) begin errors++; $display("FAIL minstret_count: got %0d exp %0d", v, 13); end
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'h4, old, ill);
    instret_i = 1'b1;
    repeat (2) tick();
    instret_i = 1'b0;
    csr_rd(ADDR_MINSTRET, v);
    checks++; if (v !== 32'd13) begin errors++; $display("FAIL ir_inhibit: got %0d exp %0d", v, 13); end
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h1236) begin errors++; $display("FAIL cy_resume: got %h exp %h", v, 32'h1236); end
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'h0, old, ill);
    instret_i = 1'b1;
    csr_do(CSR_OP_RW, ADDR_MINSTRET, 32'd100, old, ill);
    instret_i = 1'b0;
    csr_rd(ADDR_MINSTRET, v);
    checks++; if (v !== 32'd100) begin errors++; $display("FAIL instret_wr_wins: got %0d exp %0d", v, 100); end
  endtask

  task automatic test_illegal();
    logic [31:0] v, old;
    logic ill;
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'h1, old, ill);
    csr_do(CSR_OP_RW, ADDR_MCYCLE, 32'h500, old, ill);
    csr_do(CSR_OP_RW, ADDR_CYCLE, 32'hDEAD, old, ill);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL ro_write_illegal: got %b exp 1", ill); end
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h500) begin errors++; $display("FAIL ro_write_nochange: got %h exp %h", v, 32'h500); end
    csr_do(CSR_OP_RS, ADDR_CYCLE, 32'h0, old, ill);
    checks++; if ({ill, old} !== {1'b0, 32'h500}) begin errors++; $display("FAIL rs0_read: got %b/%h exp 0/%h", ill, old, 32'h500); end
    csr_do(CSR_OP_RW, 12'h7C0, 32'h1, old, ill);
    checks++; if ({ill, old} !== {1'b1, 32'h0}) begin errors++; $display("FAIL unmapped: got %b/%h exp 1/0", ill, old); end
    csr_do(CSR_OP_RW, ADDR_MHARTID, 32'h7, old, ill);
    checks++; if ({ill, old} !== {1'b1, 32'h5}) begin errors++; $display("FAIL mhartid: got %b/%h exp 1/5", ill, old); end
    csr_rd(ADDR_MISA, v);
    checks++; if (v !== 32'h4000_0100) begin errors++; $display("FAIL misa: got %h exp %h", v, 32'h4000_0100); end
    csr_do(CSR_OP_RW, ADDR_MCOUNTINH, 32'h0, old, ill);
  endtask

  task automatic test_trap();
    logic [31:0] v, old;
    logic ill;
    trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h104;
    tick();
    trap_i = 1'b0;
    checks++; if ({mepc_o, global_int_en_o} !== {32'h104, 1'b0}) begin errors++; $display("FAIL trap_mepc_mie: got %h/%b exp 104/0", mepc_o, global_int_en_o); end
    csr_rd(ADDR_MCAUSE, v);
    checks++; if (v !== 32'h8000_0007) begin errors++; $display("FAIL trap_mcause: got %h exp %h", v, 32'h8000_0007); end
    csr_rd(ADDR_MSTATUS, v);
    checks++; if (v !== 32'h1880) begin errors++; $display("FAIL trap_mstatus: got %h exp %h", v, 32'h1880); end
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    csr_rd(ADDR_MSTATUS, v);
    checks++; if ({v, global_int_en_o} !== {32'h1888, 1'b1}) begin errors++; $display("FAIL mret: got %h/%b exp 1888/1", v, global_int_en_o); end
    trap_i = 1'b1; trap_pc_i = 32'h207;
    csr_do(CSR_OP_RW, ADDR_MEPC, 32'hAAAA_0000, old, ill);
    trap_i = 1'b0;
    checks++; if (mepc_o !== 32'h204) begin errors++; $display("FAIL trap_over_wr: got %h exp %h", mepc_o, 32'h204); end
    trap_i = 1'b1; trap_pc_i = 32'h300;
    csr_do(CSR_OP_RW, ADDR_MSCRATCH, 32'h55, old, ill);
    trap_i = 1'b0;
    csr_rd(ADDR_MSCRATCH, v);
    checks++; if ({v, mepc_o} !== {32'h55, 32'h300}) begin errors++; $display("FAIL trap_other_wr: got %h/%h exp 55/300", v, mepc_o); end
    mret_i = 1'b1;
    csr_do(CSR_OP_RW, ADDR_MSTATUS, 32'h0, old, ill);
    mret_i = 1'b0;
    csr_rd(ADDR_MSTATUS, v);
    checks++; if (v !== 32'h1880) begin errors++; $display("FAIL mret_over_wr: got %h exp %h", v, 32'h1880); end
    mret_i = 1'b1;
    csr_do(CSR_OP_RW, ADDR_MEPC, 32'h400, old, ill);
    mret_i = 1'b0;
    csr_rd(ADDR_MSTATUS, v);
    checks++; if ({mepc_o, v} !== {32'h400, 32'h1888}) begin errors++; $display("FAIL mret_other_wr: got %h/%h exp 400/1888", mepc_o, v); end
    trap_cause_i = '0; trap_pc_i = '0;
  endtask

  task automatic test_irq();
    logic [31:0] v, old;
    logic ill;
    csr_do(CSR_OP_RW, ADDR_MIE, 32'h80, old, ill);
    irq_timer_i = 1'b1;
    #1;
    checks++; if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_not_yet: got %b exp 0", irq_pending_o); end
    tick();
    checks++; if (irq_pending_o !== 1'b1) begin errors++; $display("FAIL irq_timer: got %b exp 1", irq_pending_o); end
    irq_timer_i = 1'b0; irq_sw_i = 1'b1;
    tick();
    checks++; if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_masked: got %b exp 0", irq_pending_o); end
    irq_timer_i = 1'b1; irq_ext_i = 1'b1;
    tick();
    csr_rd(ADDR_MIP, v);
    checks++; if ({v, irq_pending_o} !== {32'h888, 1'b1}) begin errors++; $display("FAIL mip: got %h/%b exp 888/1", v, irq_pending_o); end
    csr_do(CSR_OP_RC, ADDR_MSTATUS, 32'h8, old, ill);
    checks++; if (irq_pending_o !== 1'b0) begin errors++; $display("FAIL irq_gmask: got %b exp 0", irq_pending_o); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    csr_rd(ADDR_MCYCLE, v);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({mepc_o, global_int_en_o, irq_pending_o} !== {32'h0, 2'b00}) begin errors++; $display("FAIL midreset_state: got %h/%b/%b exp 0/0/0", mepc_o, global_int_en_o, irq_pending_o); end
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL midreset_cnt: got %h exp %h", v, 32'h0); end
    csr_rd(ADDR_MTVEC, v);
    checks++; if (v !== 32'h1001) begin errors++; $display("FAIL midreset_mtvec: got %h exp %h", v, 32'h1001); end
    irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    csr_rd(ADDR_MCYCLE, v);
    checks++; if (v !== 32'h1) begin errors++; $display("FAIL resume_count: got %h exp %h", v, 32'h1); end
  endtask

  initial begin
    rst_n = 1'b0;
    instret_i = 1'b0; trap_i = 1'b0; trap_cause_i = '0; trap_pc_i = '0; mret_i = 1'b0;
    irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    bus.req.op = CSR_OP_NONE; bus.req.addr = '0; bus.req.wdata = '0;
    test_reset();
    test_warl();
    test_counters();
    test_illegal();
    test_trap();
    test_irq();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
